qpsk_frame_ctrl: RTL and testbench

Transmit-side symbol sequencer for the QPSK test chain. Generates repeating frames of PILOT_LEN known pilot symbols followed by DATA_LEN PRBS9 data symbols. Drives an internal `qpsk_mapper` instance and presents registered Q9.7 symbols (±90) on a valid/ready stream toward the channel model and equalizer. Start/enable control, frame markers and a frame counter let the receiver and the bench align to frame boundaries.

---
 rtl/qpsk_frame_ctrl_pkg.sv | 27 ++
 rtl/qpsk_frame_ctrl_prbs9_gen.sv | 45 ++++
 rtl/qpsk_mapper.sv | 18 +
 rtl/qpsk_frame_ctrl.sv | 162 ++++++++++++++++
 tb/tb_qpsk_frame_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qpsk_frame_ctrl_pkg.sv
// qpsk_frame_ctrl_pkg
//   Shared definitions for the QPSK transmit frame sequencer:
//   - QPSK_POS / QPSK_NEG : the two Q9.7 constellation levels (+90 / -90)
//   - PRBS9 width and feedback taps, plus a single-step helper
//   - frame_state_t       : sequencer state encoding
package qpsk_frame_ctrl_pkg;

  localparam logic signed [15:0] QPSK_POS = 16'sh005A;
  localparam logic signed [15:0] QPSK_NEG = 16'shFFA6;

  localparam int PRBS_W      = 9;
  localparam int PRBS_TAP_HI = 8;
  localparam int PRBS_TAP_LO = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PILOT = 2'd1,
    ST_DATA  = 2'd2
  } frame_state_t;

  // One Fibonacci step of x^9 + x^5 + 1: the feedback bit is shifted in at
  // bit 0, so after a step the newly generated bit is always s[0].
  function automatic logic [PRBS_W-1:0] prbs9_step(input logic [PRBS_W-1:0] s);
    return {s[PRBS_W-2:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
  endfunction

endpackage

// File: rtl/qpsk_frame_ctrl_prbs9_gen.sv
// prbs9_gen
//   PRBS9 source that produces two bits per advance.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset (loads SEED)
//     load        : reload the register with SEED
//     advance     : step the register twice (consumes bit_first/bit_second)
//     bit_first   : bit produced by the first of the two pending steps
//     bit_second  : bit produced by the second of the two pending steps
module prbs9_gen
  import qpsk_frame_ctrl_pkg::*;
#(
  parameter logic [PRBS_W-1:0] SEED = 9'h1FF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic advance,
  output logic bit_first,
  output logic bit_second
);

  logic [PRBS_W-1:0] lfsr;
  logic [PRBS_W-1:0] step1;
  logic [PRBS_W-1:0] step2;

  // The two upcoming bits are visible combinationally so the symbol being
  // loaded this cycle can use them; the register only moves on advance.
  always_comb begin
    step1      = prbs9_step(lfsr);
    step2      = prbs9_step(step1);
    bit_first  = step1[0];
    bit_second = step2[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= SEED;
    end else if (advance) begin
      lfsr <= step2;
    end
  end

endmodule

// File: rtl/qpsk_mapper.sv
// qpsk_mapper
//   Combinational bit-pair to QPSK symbol mapper (Q9.7).
//   Ports:
//     bit_i, bit_q : input bits for the I and Q rails
//     sym_i, sym_q : mapped symbols, bit 0 -> +90, bit 1 -> -90
module qpsk_mapper
  import qpsk_frame_ctrl_pkg::*;
(
  input  logic               bit_i,
  input  logic               bit_q,
  output logic signed [15:0] sym_i,
  output logic signed [15:0] sym_q
);

  assign sym_i = bit_i ? QPSK_NEG : QPSK_POS;
  assign sym_q = bit_q ? QPSK_NEG : QPSK_POS;

endmodule

// File: rtl/qpsk_frame_ctrl.sv
// qpsk_frame_ctrl
//   Transmit-side frame sequencer: PILOT_LEN pilot symbols followed by
//   DATA_LEN PRBS9 data symbols, repeated while enable is high, presented as
//   registered QPSK symbols on a valid/ready stream.
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     start             : one-cycle pulse, begins framing when idle
//     enable            : sampled at frame end; high continues with a new frame
//     sym_I, sym_Q      : Q9.7 symbol (+/-90), valid with sym_valid
//     sym_valid         : output holds a symbol
//     sym_ready         : downstream accepts the symbol this cycle
//     sof, is_pilot, eof: first pilot / pilot / last data symbol markers
//     frame_cnt         : frames completed since start
//     busy              : sequencer active or a symbol still pending
module qpsk_frame_ctrl
  import qpsk_frame_ctrl_pkg::*;
#(
  parameter int unsigned       PILOT_LEN     = 16,
  parameter int unsigned       DATA_LEN      = 240,
  parameter logic [15:0]       PILOT_PATTERN = 16'hA5F0,
  parameter logic [PRBS_W-1:0] PRBS_SEED     = 9'h1FF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               enable,
  output logic signed [15:0] sym_I,
  output logic signed [15:0] sym_Q,
  output logic               sym_valid,
  input  logic               sym_ready,
  output logic               sof,
  output logic               is_pilot,
  output logic               eof,
  output logic [15:0]        frame_cnt,
  output logic               busy
);

  localparam logic [11:0] PILOT_LAST = 12'(PILOT_LEN - 1);
  localparam logic [11:0] DATA_LAST  = 12'(DATA_LEN - 1);

  frame_state_t state, state_next, gen_state;
  logic [11:0]  sym_idx, idx_next, gen_idx;
  logic         start_ok;
  logic         load;
  logic         frame_done;
  logic [3:0]   pat_sel;
  logic         pilot_bit;
  logic         prbs_first, prbs_second, prbs_adv;
  logic         map_bit_i, map_bit_q;
  logic signed [15:0] map_i, map_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sym_idx <= '0;
    end else begin
      state   <= state_next;
      sym_idx <= idx_next;
    end
  end

  // A start accepted from IDLE is treated as the PILOT/index-0 slot in the
  // same cycle, so the first pilot is registered on the start edge and the
  // stream runs without a bubble. Everything downstream keys off gen_state
  // and gen_idx, i.e. the slot whose symbol is being loaded now.
  always_comb begin
    start_ok   = (state == ST_IDLE) && !sym_valid && start;
    gen_state  = start_ok ? ST_PILOT : state;
    gen_idx    = start_ok ? 12'd0 : sym_idx;
    load       = start_ok || ((state != ST_IDLE) && (!sym_valid || sym_ready));
    state_next = state;
    idx_next   = sym_idx;
    frame_done = 1'b0;
    if (load) begin
      case (gen_state)
        ST_PILOT: begin
          if (gen_idx == PILOT_LAST) begin
            state_next = ST_DATA;
            idx_next   = 12'd0;
          end else begin
            state_next = ST_PILOT;
            idx_next   = gen_idx + 12'd1;
          end
        end
        ST_DATA: begin
          if (gen_idx == DATA_LAST) begin
            frame_done = 1'b1;
            state_next = enable ? ST_PILOT : ST_IDLE;
            idx_next   = 12'd0;
          end else begin
            idx_next = gen_idx + 12'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pilot symbols take the pattern MSB first; data symbols take two fresh
  // PRBS bits, and the PRBS only moves when a data symbol is loaded.
  always_comb begin
    pat_sel   = 4'd15 - gen_idx[3:0];
    pilot_bit = PILOT_PATTERN[pat_sel];
    map_bit_i = (gen_state == ST_DATA) ? prbs_first  : pilot_bit;
    map_bit_q = (gen_state == ST_DATA) ? prbs_second : pilot_bit;
    prbs_adv  = load && (gen_state == ST_DATA);
  end

  prbs9_gen #(
    .SEED (PRBS_SEED)
  ) u_prbs (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (start_ok),
    .advance    (prbs_adv),
    .bit_first  (prbs_first),
    .bit_second (prbs_second)
  );

  qpsk_mapper u_mapper (
    .bit_i (map_bit_i),
    .bit_q (map_bit_q),
    .sym_i (map_i),
    .sym_q (map_q)
  );

  // Output register: loads on each accepted slot, otherwise holds. Once the
  // sequencer is idle, the last symbol stays valid until it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_I     <= '0;
      sym_Q     <= '0;
      sym_valid <= 1'b0;
      sof       <= 1'b0;
      is_pilot  <= 1'b0;
      eof       <= 1'b0;
    end else if (load) begin
      sym_I     <= map_i;
      sym_Q     <= map_q;
      sym_valid <= 1'b1;
      sof       <= (gen_state == ST_PILOT) && (gen_idx == 12'd0);
      is_pilot  <= (gen_state == ST_PILOT);
      eof       <= (gen_state == ST_DATA) && (gen_idx == DATA_LAST);
    end else if ((state == ST_IDLE) && sym_ready) begin
      sym_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (start_ok) begin
      frame_cnt <= '0;
    end else if (frame_done) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign busy = (state != ST_IDLE) || sym_valid;

endmodule

// File: tb/tb_qpsk_frame_ctrl.sv
// tb_qpsk_frame_ctrl
//   Self-checking bench for qpsk_frame_ctrl: a default-parameter instance
//   for the main stream and a PILOT_LEN=1/DATA_LEN=1 instance for the
//   shortest frame. Expected symbols come from a frame/PRBS-bit-stream model.
module tb_qpsk_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, enable, sym_ready;
  logic [15:0] sym_I, sym_Q, frame_cnt;
  logic        sym_valid, sof, is_pilot, eof, busy;

  logic        start_s, enable_s, ready_s;
  logic [15:0] sym_I_s, sym_Q_s, frame_cnt_s;
  logic        sym_valid_s, sof_s, is_pilot_s, eof_s, busy_s;

  logic [34:0] cur_main, cur_small;
  assign cur_main  = {sym_I, sym_Q, sof, is_pilot, eof};
  assign cur_small = {sym_I_s, sym_Q_s, sof_s, is_pilot_s, eof_s};

  int checks = 0;
  int errors = 0;

  bit          prbs_bits [0:4095];
  logic [34:0] cap [0:255];

  typedef struct {
    int          idx;
    logic [15:0] exp_i;
    logic [15:0] exp_q;
    logic        exp_sof;
    logic        exp_pil;
    logic        exp_eof;
    bit          chk_sym;
  } vec_t;

  vec_t vecs [0:10];

  qpsk_frame_ctrl dut (
    .clk (clk), .rst_n (rst_n), .start (start), .enable (enable),
    .sym_I (sym_I), .sym_Q (sym_Q), .sym_valid (sym_valid),
    .sym_ready (sym_ready), .sof (sof), .is_pilot (is_pilot), .eof (eof),
    .frame_cnt (frame_cnt), .busy (busy)
  );

  qpsk_frame_ctrl #(
    .PILOT_LEN (1),
    .DATA_LEN  (1)
  ) dut_small (
    .clk (clk), .rst_n (rst_n), .start (start_s), .enable (enable_s),
    .sym_I (sym_I_s), .sym_Q (sym_Q_s), .sym_valid (sym_valid_s),
    .sym_ready (ready_s), .sof (sof_s), .is_pilot (is_pilot_s), .eof (eof_s),
    .frame_cnt (frame_cnt_s), .busy (busy_s)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] map_bit(input bit b);
    return b ? 16'hFFA6 : 16'h005A;
  endfunction

  // Symbol n of the stream since start: frame f = n / frame_len, position k.
  // Data symbols consume the PRBS bit stream two bits at a time, continuing
  // across frames.
  function automatic logic [34:0] model_sym(input int n, input int plen, input int dlen);
    int          flen;
    int          f;
    int          k;
    int          d;
    logic [15:0] pat;
    bit          b;
    flen = plen + dlen;
    f    = n / flen;
    k    = n % flen;
    pat  = 16'hA5F0;
    if (k < plen) begin
      b = pat[15 - k];
      return {map_bit(b), map_bit(b), 1'(k == 0), 1'b1, 1'b0};
    end
    d = f * dlen + (k - plen);
    return {map_bit(prbs_bits[2*d]), map_bit(prbs_bits[2*d+1]), 1'b0, 1'b0,
            1'(k == flen - 1)};
  endfunction

  // Streams the main instance until 'total' symbols are accepted; optional
  // random ready, enable drop at a symbol count, and a start pulse while busy.
  task automatic applyStimulus(input int total, input bit rnd, input int drop_at,
                               input int busy_start_at);
    int          acc;
    int          cyc;
    bit          have_hold;
    bit          fired;
    bit          r;
    logic [34:0] held;
    acc       = 0;
    cyc       = 0;
    have_hold = 1'b0;
    fired     = 1'b0;
    held      = '0;
    while (acc < total && cyc < 4000) begin
      if (have_hold) begin
        checkOutput($sformatf("hold%0d", acc), 64'(cur_main), 64'(held));
        checkOutput($sformatf("hold_valid%0d", acc), 64'(sym_valid), 64'd1);
        have_hold = 1'b0;
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      sym_ready = r;
      if (acc == drop_at) enable = 1'b0;
      if (!fired && acc == busy_start_at) begin
        start = 1'b1;
        fired = 1'b1;
      end
      if (sym_valid) begin
        if (r) begin
          checkOutput($sformatf("sym%0d", acc), 64'(cur_main),
                      64'(model_sym(acc, 16, 240)));
          if (acc < 256) cap[acc] = cur_main;
          acc++;
        end else begin
          held      = cur_main;
          have_hold = 1'b1;
        end
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    if (acc < total) checkOutput("stream_timeout", 64'(acc), 64'(total));
  endtask

  task automatic drainCheck(input int exp_cnt);
    int cyc;
    cyc       = 0;
    sym_ready = 1'b1;
    while (sym_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    checkOutput("drain_valid", 64'(sym_valid), 64'd0);
    checkOutput("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
    checkOutput("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start_latency_valid", 64'(sym_valid), 64'd1);
    checkOutput("start_latency_sof", 64'(sof), 64'd1);
  endtask

  initial begin
    logic [8:0]  s;
    bit          nb;
    int          acc;
    int          cyc;
    logic [34:0] c;

    s = 9'h1FF;
    for (int i = 0; i < 4096; i++) begin
      nb           = s[8] ^ s[4];
      prbs_bits[i] = nb;
      s            = {s[7:0], nb};
    end

    vecs[0]  = '{0,   16'hFFA6, 16'hFFA6, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1,   16'h005A, 16'h005A, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{2,   16'hFFA6, 16'hFFA6, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{5,   16'hFFA6, 16'hFFA6, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{8,   16'hFFA6, 16'hFFA6, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{15,  16'h005A, 16'h005A, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{16,  16'h005A, 16'h005A, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{17,  16'h005A, 16'h005A, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{18,  16'h005A, 16'hFFA6, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{254, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{255, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n     = 1'b0;
    start     = 1'b0;
    enable    = 1'b0;
    sym_ready = 1'b1;
    start_s   = 1'b0;
    enable_s  = 1'b0;
    ready_s   = 1'b1;
    #23;
    checkOutput("rst_sym", 64'(cur_main), 64'd0);
    checkOutput("rst_valid", 64'(sym_valid), 64'd0);
    checkOutput("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] single frame, ready high");
    pulseStart();
    applyStimulus(256, 1'b0, -1, -1);
    drainCheck(1);
    for (int i = 0; i < 11; i++) begin
      c = cap[vecs[i].idx];
      if (vecs[i].chk_sym)
        checkOutput($sformatf("vec_sym%0d", vecs[i].idx), 64'(c[34:3]),
                    64'({vecs[i].exp_i, vecs[i].exp_q}));
      checkOutput($sformatf("vec_flags%0d", vecs[i].idx), 64'(c[2:0]),
                  64'({vecs[i].exp_sof, vecs[i].exp_pil, vecs[i].exp_eof}));
    end

    $display("[TB] three frames, random ready");
    enable = 1'b1;
    pulseStart();
    applyStimulus(768, 1'b1, 600, -1);
    drainCheck(3);

    $display("[TB] enable dropped in frame 2, start while busy");
    enable = 1'b1;
    pulseStart();
    applyStimulus(512, 1'b0, 300, 100);
    drainCheck(2);

    $display("[TB] reset mid-data then restart");
    enable = 1'b0;
    pulseStart();
    applyStimulus(100, 1'b0, -1, -1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_async_valid", 64'(sym_valid), 64'd0);
    checkOutput("midrst_async_sym", 64'(cur_main), 64'd0);
    tick();
    checkOutput("midrst_sym", 64'(cur_main), 64'd0);
    checkOutput("midrst_valid", 64'(sym_valid), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("midrst_no_resume", 64'(sym_valid), 64'd0);
    pulseStart();
    applyStimulus(256, 1'b0, -1, -1);
    drainCheck(1);

    $display("[TB] one pilot, one data symbol per frame");
    enable_s = 1'b1;
    start_s  = 1'b1;
    tick();
    start_s  = 1'b0;
    acc      = 0;
    cyc      = 0;
    while (acc < 8 && cyc < 100) begin
      if (acc == 6) enable_s = 1'b0;
      if (sym_valid_s) begin
        checkOutput($sformatf("small_sym%0d", acc), 64'(cur_small),
                    64'(model_sym(acc, 1, 1)));
        acc++;
      end
      tick();
      cyc++;
    end
    if (acc < 8) checkOutput("small_timeout", 64'(acc), 64'd8);
    tick();
    checkOutput("small_valid_end", 64'(sym_valid_s), 64'd0);
    checkOutput("small_frame_cnt", 64'(frame_cnt_s), 64'd4);
    checkOutput("small_busy", 64'(busy_s), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
